// File: rtl/uart_pkg.sv
// uart_pkg: shared types and line levels for the UART transmit path.
//   tx_state_t      : transmitter frame state
//   UART_*_LVL      : serial line level for idle, start and stop bits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/tx_sample_counter.sv
// tx_sample_counter: counts oversample enables within one bit period.
//   clk      in  clock
//   rst      in  synchronous reset, active-high
//   en       in  advance the counter (one oversample tick)
//   clr      in  restart the bit period (priority over en)
//   bit_end  out tick that completes the current bit period
module tx_sample_counter #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= bit_end ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, start/data/[parity]/stop, LSB first.
// Each bit is held for OVERSAMPLE pulses of sample_en.
//   clk        in  clock
//   rst        in  synchronous reset, active-high
//   sample_en  in  oversample enable, one-cycle pulses
//   tx_valid   in  tx_data holds a byte to send
//   tx_data    in  byte to send
//   tx_ready   out block idle, byte can be accepted
//   tx_serial  out serial line, idle high, registered
//   tx_busy    out frame in progress
//   tx_done    out one-cycle pulse after the last stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    tx_state_t            state, state_n;
    logic                 accept;
    logic                 bit_end;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 line_n;
    logic                 done_n;

    assign accept   = (state == IDLE) && tx_valid;
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    // Counter only runs inside a frame; accept restarts the bit period.
    tx_sample_counter #(.OVERSAMPLE(OVERSAMPLE)) u_smp (
        .clk     (clk),
        .rst     (rst),
        .en      (sample_en && (state != IDLE)),
        .clr     (accept),
        .bit_end (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (accept)
            par_q <= ^tx_data;
    end
`endif

    // ---- FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // ---- FSM: next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (tx_valid) state_n = START;
            START:  if (bit_end) state_n = DATA;
            DATA:   if (bit_end && bit_cnt == LAST_DATA)
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
            PARITY: if (bit_end) state_n = STOP;
            STOP:   if (bit_end && bit_cnt == LAST_STOP) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Shift register next value feeds the registered line level so the
    // line changes on the same edge the bit changes.
    always_comb begin
        shreg_n = shreg;
        if (accept)
            shreg_n = tx_data;
        else if (state == DATA && bit_end)
            shreg_n = shreg >> 1;
    end

    // ---- FSM: outputs (pre-register)
    always_comb begin
        line_n = UART_IDLE_LVL;
        case (state_n)
            IDLE:   line_n = UART_IDLE_LVL;
            START:  line_n = UART_START_LVL;
            DATA:   line_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: line_n = par_q;
`endif
            STOP:   line_n = UART_STOP_LVL;
            default: line_n = UART_IDLE_LVL;
        endcase
        done_n = (state == STOP) && (state_n == IDLE);
    end

    // Bit counter restarts on every state change, so it indexes data bits
    // in DATA and stop bits in STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            shreg <= shreg_n;
            if (state_n != state)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + BCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_serial <= UART_IDLE_LVL;
            tx_done   <= 1'b0;
        end else begin
            tx_serial <= line_n;
            tx_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LEN = 1 + DB + PB + SB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_ready, tx_serial, tx_busy, tx_done;

    uart_tx_serializer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference: a frame is a list of line levels, each held for OS pulses.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_acc  = 1'b0;
    int m_k    = 0;
    bit m_bits [LEN];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic build(input logic [DB-1:0] d);
        m_bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) m_bits[1+i] = d[i];
        if (PB == 1) m_bits[1+DB] = ^d;
        for (int i = 0; i < SB; i++) m_bits[1+DB+PB+i] = 1'b1;
    endtask

    // One clock: drive, advance the model at the edge, compare at negedge.
    task automatic step(input logic se, input logic v, input logic [DB-1:0] d, input logic r);
        bit exp_line;
        sample_en = se; tx_valid = v; tx_data = d; rst = r;
        @(posedge clk);
        m_acc = 1'b0;
        if (r) begin
            m_busy = 1'b0; m_done = 1'b0; m_k = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (v) begin
                build(d); m_busy = 1'b1; m_k = 0; m_acc = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (se) m_k++;
            if (m_k == LEN * OS) begin
                m_busy = 1'b0; m_done = 1'b1;
            end
        end
        @(negedge clk);
        exp_line = m_busy ? m_bits[m_k / OS] : 1'b1;
        chk("serial", 32'(tx_serial), 32'(exp_line));
        chk("ready",  32'(tx_ready),  32'(!m_busy));
        chk("busy",   32'(tx_busy),   32'(m_busy));
        chk("done",   32'(tx_done),   32'(m_done));
    endtask

    // Run with a given enable period (1 = every cycle) until done; returns
    // cycles from the accepting edge. Pulse j falls on step j when j%per==0.
    task automatic run_to_done(input int per, input int start_j, input int limit, output int n);
        bit seen = 1'b0;
        n = start_j;
        while (!seen && n < limit) begin
            n++;
            step((n % per) == 0, 1'b0, '0, 1'b0);
            seen = tx_done;
        end
        if (!seen) chk("timeout_done", 32'(n), 32'(limit + 1));
    endtask

    initial begin
        int n;
        int gap;
        logic [DB-1:0] d;

        // Reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // 0xA5, enable every cycle: done 160 cycles after accept
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        chk("acc_a5", 32'(m_acc), 32'(1));
        run_to_done(1, 0, 400, n);
        chk("lat_a5", 32'(n), 32'(LEN * OS));
        repeat (3) step(1'b1, 1'b0, '0, 1'b0);

        // Reset during data bit 3 (frame bit 4)
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        repeat (4 * OS + 5) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("rst_line", 32'(tx_serial), 32'(1));
        repeat (OS * LEN) step(1'b1, 1'b0, '0, 1'b0);

        // 0x00, enable every 4th cycle: 640-cycle frame
        step(1'b0, 1'b1, 8'h00, 1'b0);
        run_to_done(4, 0, 1000, n);
        chk("lat_00", 32'(n), 32'(LEN * OS * 4));
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);

        // Valid held: 0x01 then 0x80 accepted in the done cycle
        step(1'b1, 1'b1, 8'h01, 1'b0);
        gap = 0;
        do begin
            gap++;
            step(1'b1, 1'b1, 8'h80, 1'b0);
        end while (!m_acc && gap < 400);
        chk("b2b_gap", 32'(gap), 32'(LEN * OS + 1));
        run_to_done(1, 0, 400, n);
        chk("lat_80", 32'(n), 32'(LEN * OS));
        step(1'b1, 1'b0, '0, 1'b0);

        // 0xFF pulse mid-frame must be ignored
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        repeat (50) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        run_to_done(1, 51, 400, n);
        chk("lat_ign", 32'(n), 32'(LEN * OS));
        repeat (40) step(1'b1, 1'b0, '0, 1'b0);
        chk("no_frame2", 32'(tx_busy), 32'(0));

`ifdef UART_TX_PARITY_EN
        step(1'b1, 1'b1, 8'h07, 1'b0);
        run_to_done(1, 0, 400, n);
        chk("lat_p07", 32'(n), 32'(176));
        step(1'b1, 1'b1, 8'h03, 1'b0);
        run_to_done(1, 0, 400, n);
        chk("lat_p03", 32'(n), 32'(176));
`endif

        // Random traffic, sparse resets
        for (int i = 0; i < 5000; i++) begin
            d = DB'($urandom);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, d,
                 $urandom_range(0, 1999) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
